spi_tx_engine: RTL

//  Parametrised transmit-only SPI master; successor to the fixed 16-bit, mode-0, div-by-4 master.

---
 rtl/spi_tx_engine.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/spi_tx_engine.sv
// Transmit-only SPI master: parametrised word width, SCK divider, CPOL/CPHA and CS gap,
// valid/ready word input with optional burst (cs_n held low between words).
module spi_tx_engine #(
    parameter int WORD_W  = 16,
    parameter int CLK_DIV = 2,
    parameter int CPOL    = 0,
    parameter int CPHA    = 0,
    parameter int CS_GAP  = 1
) (
    input  logic              clk_i,
    input  logic              res_i,
    input  logic [WORD_W-1:0] word_in_i,
    input  logic              word_valid_i,
    input  logic              hold_cs_i,
    output logic              word_ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              sck_o,
    output logic              mosi_o,
    output logic              cs_n_o
);
    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam int EW = $clog2(WORD_W) + 1;
    localparam int GW = $clog2(CS_GAP) + 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * WORD_W - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);
    localparam logic          CPOL_B    = (CPOL != 0);
    localparam logic          CPHA_B    = (CPHA != 0);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, BWAIT, GAP} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [EW-1:0]       edge_q, edge_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic                hold_q, hold_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic                cs_n_q, cs_n_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                accept;
    logic                sample_edge;

    assign accept      = word_valid_i & ready_q;
    // Edge index parity: even edges are leading, odd edges trailing.
    assign sample_edge = (edge_q[0] == CPHA_B);

    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            edge_q  <= '0;
            gap_q   <= '0;
            shift_q <= '0;
            hold_q  <= 1'b0;
            sck_q   <= CPOL_B;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            gap_q   <= gap_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        gap_d   = gap_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        case (state_q)
            IDLE, BWAIT: begin
                sck_d = CPOL_B;
                if (accept) begin
                    state_d = SETUP;
                    shift_d = word_in_i;
                    hold_d  = hold_cs_i;
                    mosi_d  = word_in_i[WORD_W-1];
                    cnt_d   = '0;
                end
            end
            SETUP: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    edge_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    sck_d  = ~sck_q;
                    edge_d = edge_q + 1'b1;
                    // Advance on non-sampling edges after the first sample; the last edge keeps the final bit.
                    if (!sample_edge && edge_q != '0 && edge_q != EDGE_LAST) begin
                        shift_d = {shift_q[WORD_W-2:0], 1'b0};
                        mosi_d  = shift_q[WORD_W-2];
                    end
                    if (edge_q == EDGE_LAST) begin
                        state_d = HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    gap_d = '0;
                    if (hold_q) begin
                        state_d = BWAIT;
                    end else begin
                        state_d = GAP;
                        mosi_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                mosi_d = 1'b0;
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they align with state_q.
        cs_n_d  = (state_d == IDLE) || (state_d == GAP);
        ready_d = (state_d == IDLE) || (state_d == BWAIT);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == HOLD) && (cnt_d == CNT_LAST);
    end

    assign word_ready_o = ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign sck_o        = sck_q;
    assign mosi_o       = mosi_q;
    assign cs_n_o       = cs_n_q;
endmodule
